dffram_burst_seq: RTL and testbench

Command sequencer that sits directly upstream of the 32x4 2R1W DFF RAM and drives its write port A and read port B. It accepts one command at a time: LOAD (streamed burst write), FILL (constant-pattern write) or VERIFY (stream-compare read-back). Addresses auto-increment. It reports completion and the first mismatch, so the RAM can be initialised and self-checked without per-word pin toggling.

---
 rtl/dffram_burst_seq_if.sv | 40 ++++
 rtl/dffram_burst_seq.sv | 125 ++++++++++++
 tb/tb_dffram_burst_seq.sv | 259 +++++++++++++++++++++++++
 3 files changed

// File: rtl/dffram_burst_seq_if.sv
// Command, stream and RAM-port bundle between a command issuer and the burst sequencer.
// master = command/stream source and RAM model side, slave = sequencer.
interface dffram_burst_seq_if #(
  parameter int ADDRWIDTH = 5,
  parameter int DWIDTH    = 4
);
  logic                 cmd_valid;
  logic                 cmd_ready;
  logic [1:0]           cmd_op;
  logic [ADDRWIDTH-1:0] cmd_addr;
  logic [ADDRWIDTH-1:0] cmd_len;
  logic [DWIDTH-1:0]    cmd_pat;
  logic                 din_valid;
  logic                 din_ready;
  logic [DWIDTH-1:0]    din_data;
  logic                 abort;
  logic [ADDRWIDTH-1:0] ram_addr_a;
  logic [DWIDTH-1:0]    ram_wdata;
  logic                 ram_w_en;
  logic [ADDRWIDTH-1:0] ram_addr_b;
  logic [DWIDTH-1:0]    ram_rdata_b;
  logic                 busy;
  logic                 done;
  logic                 err;
  logic [ADDRWIDTH-1:0] err_addr;

  modport master (
    output cmd_valid, cmd_op, cmd_addr, cmd_len, cmd_pat,
    output din_valid, din_data, abort, ram_rdata_b,
    input  cmd_ready, din_ready, ram_addr_a, ram_wdata, ram_w_en,
    input  ram_addr_b, busy, done, err, err_addr
  );

  modport slave (
    input  cmd_valid, cmd_op, cmd_addr, cmd_len, cmd_pat,
    input  din_valid, din_data, abort, ram_rdata_b,
    output cmd_ready, din_ready, ram_addr_a, ram_wdata, ram_w_en,
    output ram_addr_b, busy, done, err, err_addr
  );
endinterface

// File: rtl/dffram_burst_seq.sv
// Burst LOAD/FILL/VERIFY sequencer for the 32x4 DFF RAM; one word per accepted beat, done 1 cycle after last beat.
// Backpressure: cmd_ready only in IDLE; din_ready only in LOAD/VERIFY and dropped while abort is high.
module dffram_burst_seq #(
  parameter int ADDRWIDTH = 5,
  parameter int DWIDTH    = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  dffram_burst_seq_if.slave  bus
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_FILL,
    S_VERIFY,
    S_DONE
  } state_t;

  state_t               state, state_nxt;
  logic [ADDRWIDTH-1:0] ptr, ptr_nxt;
  logic [ADDRWIDTH-1:0] cnt, cnt_nxt;
  logic [DWIDTH-1:0]    pat, pat_nxt;
  logic                 err_q, err_nxt;
  logic [ADDRWIDTH-1:0] err_addr_q, err_addr_nxt;
  logic                 step;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= S_IDLE;
      ptr        <= '0;
      cnt        <= '0;
      pat        <= '0;
      err_q      <= 1'b0;
      err_addr_q <= '0;
    end else begin
      state      <= state_nxt;
      ptr        <= ptr_nxt;
      cnt        <= cnt_nxt;
      pat        <= pat_nxt;
      err_q      <= err_nxt;
      err_addr_q <= err_addr_nxt;
    end
  end

  always_comb begin
    state_nxt     = state;
    ptr_nxt       = ptr;
    cnt_nxt       = cnt;
    pat_nxt       = pat;
    err_nxt       = err_q;
    err_addr_nxt  = err_addr_q;
    step          = 1'b0;
    bus.cmd_ready = 1'b0;
    bus.din_ready = 1'b0;
    bus.ram_w_en  = 1'b0;
    bus.ram_wdata = '0;
    bus.done      = 1'b0;
    bus.busy      = 1'b1;

    case (state)
      S_IDLE: begin
        bus.busy      = 1'b0;
        bus.cmd_ready = 1'b1;
        if (bus.cmd_valid) begin
          ptr_nxt      = bus.cmd_addr;
          cnt_nxt      = bus.cmd_len;
          pat_nxt      = bus.cmd_pat;
          err_nxt      = 1'b0;
          err_addr_nxt = '0;
          case (bus.cmd_op)
            2'd0:    state_nxt = S_LOAD;
            2'd1:    state_nxt = S_FILL;
            2'd2:    state_nxt = S_VERIFY;
            default: state_nxt = S_DONE;
          endcase
        end
      end
      S_LOAD: begin
        bus.din_ready = !bus.abort;
        bus.ram_w_en  = bus.din_valid && !bus.abort;
        bus.ram_wdata = bus.din_data;
        if (bus.abort)          state_nxt = S_DONE;
        else if (bus.din_valid) step      = 1'b1;
      end
      S_FILL: begin
        bus.ram_w_en  = !bus.abort;
        bus.ram_wdata = pat;
        if (bus.abort) state_nxt = S_DONE;
        else           step      = 1'b1;
      end
      S_VERIFY: begin
        bus.din_ready = !bus.abort;
        if (bus.abort) begin
          state_nxt = S_DONE;
        end else if (bus.din_valid) begin
          step = 1'b1;
          // Only the first mismatch of a command is recorded.
          if ((bus.din_data != bus.ram_rdata_b) && !err_q) begin
            err_nxt      = 1'b1;
            err_addr_nxt = ptr;
          end
        end
      end
      S_DONE: begin
        bus.done  = 1'b1;
        state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase

    // ptr wraps naturally at 2^ADDRWIDTH, so bursts may cross the top of the RAM.
    if (step) begin
      ptr_nxt = ptr + 1'b1;
      if (cnt == '0) state_nxt = S_DONE;
      else           cnt_nxt   = cnt - 1'b1;
    end
  end

  assign bus.ram_addr_a = ptr;
  assign bus.ram_addr_b = ptr;
  assign bus.err        = err_q;
  assign bus.err_addr   = err_addr_q;

endmodule

// File: tb/tb_dffram_burst_seq.sv
// Directed bench for dffram_burst_seq with a behavioural 32x4 RAM on the RAM ports.
// Expected writes and done status are queued by stimulus and popped by a negedge monitor.
module tb_dffram_burst_seq;

  logic clk;
  logic rst_n;
  int   n_checks = 0;
  int   n_errors = 0;
  int   wr_cnt   = 0;
  int   busy_cnt = 0;

  logic [3:0] mem [32];
  logic [8:0] exp_wr [$];
  logic [5:0] exp_done [$];

  dffram_burst_seq_if #(.ADDRWIDTH(5), .DWIDTH(4)) bus ();

  dffram_burst_seq #(.ADDRWIDTH(5), .DWIDTH(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) if (bus.ram_w_en) mem[bus.ram_addr_a] <= bus.ram_wdata;
  assign bus.ram_rdata_b = mem[bus.ram_addr_b];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (rst_n) begin
      if (bus.busy) busy_cnt++;
      if (bus.ram_w_en) begin
        wr_cnt++;
        if (exp_wr.size() == 0) check("unexpected_write", {bus.ram_addr_a, bus.ram_wdata}, 9'h1ff);
        else                    check("write_addr_data", {bus.ram_addr_a, bus.ram_wdata}, exp_wr.pop_front());
      end
      if (bus.done) begin
        if (exp_done.size() == 0) check("unexpected_done", {bus.err, bus.err_addr}, 6'h3f);
        else                      check("done_err_status", {bus.err, bus.err_addr}, exp_done.pop_front());
      end
    end
  end

  task automatic check_reset_outputs(input string tag);
    check({tag, "_cmd_ready"}, bus.cmd_ready, 1);
    check({tag, "_din_ready"}, bus.din_ready, 0);
    check({tag, "_busy"},      bus.busy, 0);
    check({tag, "_done"},      bus.done, 0);
    check({tag, "_w_en"},      bus.ram_w_en, 0);
    check({tag, "_addr_a"},    bus.ram_addr_a, 0);
    check({tag, "_addr_b"},    bus.ram_addr_b, 0);
    check({tag, "_wdata"},     bus.ram_wdata, 0);
    check({tag, "_err"},       bus.err, 0);
    check({tag, "_err_addr"},  bus.err_addr, 0);
  endtask

  // Returns at posedge+1 just after the accepting edge.
  task automatic issue(input logic [1:0] op, input logic [4:0] addr, input logic [4:0] len,
                       input logic [3:0] pat);
    bit ok = 1'b0;
    int t  = 0;
    bus.cmd_valid = 1'b1;
    bus.cmd_op    = op;
    bus.cmd_addr  = addr;
    bus.cmd_len   = len;
    bus.cmd_pat   = pat;
    while (!ok && t < 20) begin
      @(negedge clk);
      ok = bus.cmd_ready;
      @(posedge clk);
      #1;
      t++;
    end
    bus.cmd_valid = 1'b0;
    check("cmd_accepted", ok, 1);
  endtask

  task automatic send_word(input logic [3:0] d);
    bit ok = 1'b0;
    int t  = 0;
    bus.din_valid = 1'b1;
    bus.din_data  = d;
    while (!ok && t < 20) begin
      @(negedge clk);
      ok = bus.din_ready;
      @(posedge clk);
      #1;
      t++;
    end
    bus.din_valid = 1'b0;
    check("din_accepted", ok, 1);
  endtask

  task automatic wait_done();
    bit seen = 1'b0;
    int t    = 0;
    while (!seen && t < 200) begin
      @(negedge clk);
      seen = bus.done;
      t++;
    end
    @(posedge clk);
    #1;
    check("done_seen", seen, 1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int w0;
    int b0;
    for (int i = 0; i < 32; i++) mem[i] = 4'h0;
    rst_n         = 1'b0;
    bus.cmd_valid = 1'b0;
    bus.cmd_op    = 2'd0;
    bus.cmd_addr  = '0;
    bus.cmd_len   = '0;
    bus.cmd_pat   = '0;
    bus.din_valid = 1'b0;
    bus.din_data  = '0;
    bus.abort     = 1'b0;
    #2;
    check_reset_outputs("por");
    #10 rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Reset in the middle of a full-RAM FILL: only words 0..4 land.
    for (int i = 0; i < 5; i++) exp_wr.push_back({5'(i), 4'hA});
    issue(2'd1, 5'd0, 5'd31, 4'hA);
    repeat (5) @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    check_reset_outputs("midfill");
    check("midfill_writes_left", exp_wr.size(), 0);
    for (int i = 0; i < 32; i++) check("midfill_mem", mem[i], (i < 5) ? 4'hA : 4'h0);
    #3 rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Full FILL with 0x5, then VERIFY all words through port B.
    for (int i = 0; i < 32; i++) exp_wr.push_back({5'(i), 4'h5});
    exp_done.push_back(6'h00);
    w0 = wr_cnt;
    issue(2'd1, 5'd0, 5'd31, 4'h5);
    wait_done();
    check("fill_write_cycles", wr_cnt - w0, 32);
    exp_done.push_back(6'h00);
    issue(2'd2, 5'd0, 5'd31, 4'h0);
    for (int i = 0; i < 32; i++) send_word(4'h5);
    wait_done();
    check("fill_verify_err", bus.err, 0);

    // LOAD across the wrap with one idle beat.
    exp_wr.push_back({5'd30, 4'h1});
    exp_wr.push_back({5'd31, 4'h2});
    exp_wr.push_back({5'd0,  4'h3});
    exp_wr.push_back({5'd1,  4'h4});
    exp_done.push_back(6'h00);
    w0 = wr_cnt;
    issue(2'd0, 5'd30, 5'd3, 4'h0);
    send_word(4'h1);
    send_word(4'h2);
    @(negedge clk);
    check("gap_no_write", bus.ram_w_en, 0);
    @(posedge clk);
    #1;
    send_word(4'h3);
    send_word(4'h4);
    @(negedge clk);
    check("load_done_after_last", bus.done, 1);
    @(posedge clk);
    #1;
    check("load_write_count", wr_cnt - w0, 4);
    check("load_mem30", mem[30], 4'h1);
    check("load_mem31", mem[31], 4'h2);
    check("load_mem0",  mem[0],  4'h3);
    check("load_mem1",  mem[1],  4'h4);

    // VERIFY with a bad third word: mismatch lands at the wrapped address 0.
    exp_done.push_back({1'b1, 5'd0});
    issue(2'd2, 5'd30, 5'd3, 4'h0);
    send_word(4'h1);
    send_word(4'h2);
    send_word(4'h7);
    send_word(4'h4);
    wait_done();
    check("verify_err_sticky", bus.err, 1);
    check("verify_err_addr", bus.err_addr, 0);

    // Next accept clears the sticky error.
    exp_wr.push_back({5'd16, 4'hC});
    exp_done.push_back(6'h00);
    issue(2'd1, 5'd16, 5'd0, 4'hC);
    check("err_cleared_on_accept", bus.err, 0);
    check("err_addr_cleared", bus.err_addr, 0);
    wait_done();

    // Abort on the second LOAD beat.
    exp_wr.push_back({5'd8, 4'h9});
    exp_done.push_back(6'h00);
    issue(2'd0, 5'd8, 5'd7, 4'h0);
    send_word(4'h9);
    bus.din_valid = 1'b1;
    bus.din_data  = 4'h6;
    bus.abort     = 1'b1;
    #1;
    check("abort_din_ready", bus.din_ready, 0);
    check("abort_no_write", bus.ram_w_en, 0);
    @(posedge clk);
    #1;
    bus.abort     = 1'b0;
    bus.din_valid = 1'b0;
    check("abort_done", bus.done, 1);
    @(posedge clk);
    #1;
    check("abort_ready_after_done", bus.cmd_ready, 1);
    check("abort_mem8", mem[8], 4'h9);
    check("abort_mem9", mem[9], 4'h5);

    // Reserved op: one busy cycle, done right after accept, no writes.
    exp_done.push_back(6'h00);
    w0 = wr_cnt;
    b0 = busy_cnt;
    issue(2'd3, 5'd4, 5'd2, 4'hF);
    @(negedge clk);
    check("rsv_done", bus.done, 1);
    check("rsv_busy", bus.busy, 1);
    @(posedge clk);
    #1;
    check("rsv_done_gone", bus.done, 0);
    check("rsv_ready", bus.cmd_ready, 1);
    repeat (3) @(posedge clk);
    #1;
    check("rsv_busy_cycles", busy_cnt - b0, 1);
    check("rsv_no_write", wr_cnt - w0, 0);

    check("writes_outstanding", exp_wr.size(), 0);
    check("dones_outstanding", exp_done.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
